// File: rtl/alu_ctrl_md_pkg.sv
// Shared encodings for the ALU controller: ALUOp and funct codes, ALU control
// codes, sequencer state, and the combinational ALU control decode.
package alu_ctrl_md_pkg;

    localparam logic [2:0] ALUOP_MEM   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLTI  = 3'b011;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic [3:0] decode_alu_ctrl(input logic [2:0] aluop,
                                                   input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = CTRL_NONE;
        case (aluop)
            ALUOP_MEM:  ctrl = CTRL_ADD;
            ALUOP_BEQ:  ctrl = CTRL_SUB;
            ALUOP_SLTI: ctrl = CTRL_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_ADD;
                    FUNCT_SUB: ctrl = CTRL_SUB;
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_NOR: ctrl = CTRL_NOR;
                    FUNCT_SLT: ctrl = CTRL_SLT;
                    default:   ctrl = CTRL_NONE;
                endcase
            end
            default: ctrl = CTRL_NONE;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// {P_hi, P_lo} holds {HI, LO} for multiply and {remainder, quotient} for divide.
module md_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_op_div,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]    r_count;
    logic                r_div;
    logic [DATA_W-1:0]   r_opnd;
    logic [2*DATA_W-1:0] r_p;

    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_p_next;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        w_p_next  = r_p;
        w_mul_sum = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh  = r_p[2*DATA_W-1:DATA_W-1];
        w_diff    = w_rem_sh - {1'b0, r_opnd};
        if (r_div) begin
            if (!w_diff[DATA_W])
                w_p_next = {w_diff[DATA_W-1:0], r_p[DATA_W-2:0], 1'b1};
            else
                w_p_next = {r_p[2*DATA_W-2:DATA_W-1], r_p[DATA_W-2:0], 1'b0};
        end else begin
            w_p_next = {w_mul_sum, r_p[DATA_W-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_start)
            r_count <= '0;
        else if (i_run)
            r_count <= r_count + 1'b1;
    end

    // NOTE: datapath registers carry no reset; they are always loaded on start
    // before any result derived from them is consumed.
    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_div  <= i_op_div;
            r_opnd <= i_op_div ? i_b : i_a;
            r_p    <= {{DATA_W{1'b0}}, (i_op_div ? i_a : i_b)};
        end else if (i_run) begin
            r_p    <= w_p_next;
        end
    end

    assign o_last = i_run & (r_count == CNT_W'(DATA_W - 1));
    assign o_hi   = w_p_next[2*DATA_W-1:DATA_W];
    assign o_lo   = w_p_next[DATA_W-1:0];

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU controller: ALUOp/funct decode, MULTU/DIVU sequencer with HI/LO,
// MFHI/MFLO read-out and the pipeline stall handshake.
module alu_ctrl_md
    import alu_ctrl_md_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic               issue_i,
    input  logic [DATA_W-1:0]  rs_data_i,
    input  logic [DATA_W-1:0]  rt_data_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               mf_valid_o,
    output logic [DATA_W-1:0]  mf_data_o,
    output logic               busy_o,
    output logic               stall_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_done;

    logic              w_rtype;
    logic              w_md_req;
    logic              w_mf_req;
    logic              w_busy;
    logic              w_start;
    logic              w_last;
    logic [DATA_W-1:0] w_res_hi;
    logic [DATA_W-1:0] w_res_lo;

    assign ALUCtrl_o = decode_alu_ctrl(ALUOp_i, funct_i);
    assign w_rtype   = (ALUOp_i == ALUOP_RTYPE);
    assign w_md_req  = issue_i & w_rtype & ((funct_i == FUNCT_MULTU) | (funct_i == FUNCT_DIVU));
    assign w_mf_req  = issue_i & w_rtype & ((funct_i == FUNCT_MFHI) | (funct_i == FUNCT_MFLO));

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_md_req)
                    w_state_next = (funct_i == FUNCT_DIVU) ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (w_last)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_start = (r_state == ST_IDLE) & w_md_req;
    end

    md_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_start  (w_start),
        .i_op_div (funct_i == FUNCT_DIVU),
        .i_run    (w_busy),
        .i_a      (rs_data_i),
        .i_b      (rt_data_i),
        .o_last   (w_last),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    // HI/LO are written only on the final iteration; reset aborts without a write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    always_comb begin
        mf_data_o = '0;
        if (w_mf_req && funct_i == FUNCT_MFHI)
            mf_data_o = r_hi;
        else if (w_mf_req && funct_i == FUNCT_MFLO)
            mf_data_o = r_lo;
    end

    assign busy_o     = w_busy;
    assign stall_o    = w_busy & (w_md_req | w_mf_req);
    assign mf_valid_o = w_mf_req & ~w_busy;
    assign done_o     = r_done;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed self-checking bench for alu_ctrl_md: decode table, MULTU/DIVU results
// and latency, MF stall handshake, back-to-back issue and mid-operation reset.
module tb_alu_ctrl_md;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [2:0]  aluop;
    logic        issue;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  alu_ctrl;
    logic        mf_valid;
    logic [31:0] mf_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } dec_vec_t;

    dec_vec_t dec_tbl [0:18] = '{
        '{3'b000, 6'b100010, 4'b0010},
        '{3'b001, 6'b100000, 4'b0110},
        '{3'b011, 6'b000000, 4'b0111},
        '{3'b100, 6'b100000, 4'b1111},
        '{3'b101, 6'b100000, 4'b1111},
        '{3'b110, 6'b100000, 4'b1111},
        '{3'b111, 6'b100000, 4'b1111},
        '{3'b010, 6'b100000, 4'b0010},
        '{3'b010, 6'b100010, 4'b0110},
        '{3'b010, 6'b100100, 4'b0000},
        '{3'b010, 6'b100101, 4'b0001},
        '{3'b010, 6'b100111, 4'b1100},
        '{3'b010, 6'b101010, 4'b0111},
        '{3'b010, 6'b011001, 4'b1111},
        '{3'b010, 6'b011011, 4'b1111},
        '{3'b010, 6'b010000, 4'b1111},
        '{3'b010, 6'b010010, 4'b1111},
        '{3'b010, 6'b011000, 4'b1111},
        '{3'b010, 6'b011010, 4'b1111}
    };

    alu_ctrl_md dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .funct_i    (funct),
        .ALUOp_i    (aluop),
        .issue_i    (issue),
        .rs_data_i  (rs),
        .rt_data_i  (rt),
        .ALUCtrl_o  (alu_ctrl),
        .mf_valid_o (mf_valid),
        .mf_data_o  (mf_data),
        .busy_o     (busy),
        .stall_o    (stall),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; issue = 1'b0; funct = 6'd0; aluop = 3'd0; rs = '0; rt = '0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_decode();
        issue = 1'b0;
        for (int i = 0; i < 19; i++) begin
            aluop = dec_tbl[i].op;
            funct = dec_tbl[i].fn;
            #1;
            checks++;
            if (alu_ctrl !== dec_tbl[i].exp) begin
                errors++;
                $display("FAIL decode[%0d] op=%b fn=%b: got %b expected %b",
                         i, aluop, funct, alu_ctrl, dec_tbl[i].exp);
            end
        end
        aluop = 3'b010; funct = 6'b011000; issue = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL decode_mult_no_busy: got %b expected 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL decode_mult_no_stall: got %b expected 0", stall); end
        issue = 1'b0;
        step();
    endtask

    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int n;
        aluop = 3'b010; funct = fn; rs = a; rt = b; issue = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_accept_stall: got %b expected 0", name, stall); end
        step();
        issue = 1'b0; funct = 6'b100000;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 32", name, n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, done); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, done); end
    endtask

    task automatic test_multu();
        run_md(6'b011001, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001, "multu_ffff");
        run_md(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    endtask

    task automatic test_divu();
        run_md(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        run_md(6'b011011, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, "divu_by_zero");
    endtask

    task automatic test_mf_stall();
        int n;
        int bad;
        aluop = 3'b010; funct = 6'b011001; rs = 32'h00010000; rt = 32'h00030005; issue = 1'b1;
        step();
        issue = 1'b0;
        step();
        aluop = 3'b010; funct = 6'b100000; issue = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_busy_stall: got %b expected 0", stall); end
        checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL add_busy_ctrl: got %b expected 0010", alu_ctrl); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_busy: got %b expected 1", busy); end
        step(); step(); step(); step();
        funct = 6'b010010;
        #1;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall !== 1'b1 || mf_valid !== 1'b0) bad++;
            n++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mflo_held: %0d cycles without stall, expected 0", bad); end
        checks++; if (n != 27) begin errors++; $display("FAIL mflo_stall_cycles: got %0d expected 27", n); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mflo_release_stall: got %b expected 0", stall); end
        checks++; if (mf_valid !== 1'b1) begin errors++; $display("FAIL mflo_valid: got %b expected 1", mf_valid); end
        checks++; if (mf_data !== 32'h00050000) begin errors++; $display("FAIL mflo_data: got %h expected 00050000", mf_data); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mflo_done: got %b expected 1", done); end
        funct = 6'b010000;
        #1;
        checks++; if (mf_data !== 32'h00000003) begin errors++; $display("FAIL mfhi_data: got %h expected 00000003", mf_data); end
        issue = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        aluop = 3'b010; funct = 6'b011001; rs = 32'h12345678; rt = 32'h00000010; issue = 1'b1;
        step();
        funct = 6'b011011; rs = 32'd1000; rt = 32'd7;
        #1;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall !== 1'b1) bad++;
            n++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_held: %0d cycles without stall, expected 0", bad); end
        checks++; if (n != 32) begin errors++; $display("FAIL b2b_first_cycles: got %0d expected 32", n); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL b2b_first_hi: got %h expected 00000001", hi); end
        checks++; if (lo !== 32'h23456780) begin errors++; $display("FAIL b2b_first_lo: got %h expected 23456780", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_release_stall: got %b expected 0", stall); end
        step();
        issue = 1'b0; funct = 6'b100000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b expected 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL b2b_second_cycles: got %0d expected 32", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done); end
        checks++; if (hi !== 32'd6) begin errors++; $display("FAIL b2b_second_hi: got %h expected 00000006", hi); end
        checks++; if (lo !== 32'd142) begin errors++; $display("FAIL b2b_second_lo: got %h expected 0000008e", lo); end
        step();
    endtask

    task automatic test_reset_abort();
        int bad;
        aluop = 3'b010; funct = 6'b011011; rs = 32'd100; rt = 32'd7; issue = 1'b1;
        step();
        issue = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1; issue = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 0", lo); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
        rst = 1'b0; issue = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: %0d cycles with busy/done, expected 0", bad); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo_kept: got %h expected 0", lo); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_multu();
        test_divu();
        test_mf_stall();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
Next-generation ALU controller for the MIPS single-cycle/pipelined CPU. It keeps the combinational ALUOp/funct decode to a 4-bit ALU control code and adds an iterative multi-cycle unsigned multiply/divide sequencer with HI/LO registers, MFHI/MFLO read-out and a pipeline stall handshake. It sits beside the ALU in the EX stage and is driven by the main decoder's ALUOp and the register-file read data.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count of MULTU/DIVU (1 bit per cycle)
FUNCT_W, 6, funct field width
ALUOP_W, 3, ALUOp width
CTRL_W, 4, ALU control code width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
funct_i  in  FUNCT_W  instruction funct field
ALUOp_i  in  ALUOP_W  from main decoder
issue_i  in  1  instruction in EX is valid this cycle
rs_data_i  in  DATA_W  multiplicand / dividend
rt_data_i  in  DATA_W  multiplier / divisor
ALUCtrl_o  out  CTRL_W  ALU operation code (combinational)
mf_valid_o  out  1  MFHI/MFLO result present on mf_data_o (combinational)
mf_data_o  out  DATA_W  HI or LO contents
busy_o  out  1  sequencer running
stall_o  out  1  hold PC/IF/ID/EX this cycle (combinational)
done_o  out  1  one-cycle pulse: HI/LO just updated
hi_o  out  DATA_W  HI register
lo_o  out  DATA_W  LO register

Behaviour:
- Decode (combinational, independent of state):
  - ALUOp 000 -> 0010 (lw/sw add); 001 -> 0110 (beq sub); 011 -> 0111 (slti).
  - ALUOp 010 (R-type) by funct:
    - 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 100111 -> 1100 (NOR); 101010 -> 0111.
    - 011001 MULTU, 011011 DIVU, 010000 MFHI, 010010 MFLO -> 1111 (no ALU result).
    - Any other funct (including signed MULT/DIV) -> 1111.
  - Any other ALUOp -> 1111.
- md_req = issue_i & R-type & funct in {MULTU, DIVU}; mf_req = issue_i & R-type & funct in {MFHI, MFLO}.
- States: IDLE, MUL, DIV.
  - IDLE: on md_req, latch operands, clear the iteration counter, go to MUL or DIV. The accept edge is edge N.
  - MUL/DIV: perform one shift-add or restoring-subtract step per cycle. After DATA_W steps, write HI/LO at edge N+DATA_W and return to IDLE.
- busy_o = (state != IDLE). It is high for exactly DATA_W cycles after the accept edge.
- done_o is high for the single cycle after the HI/LO write edge.
- stall_o = busy_o & (md_req | mf_req). Other instructions proceed while busy. An md_req or mf_req held by stall is accepted or served in the first cycle busy_o is low.
- mf_valid_o = mf_req & ~busy_o. mf_data_o = HI for MFHI, LO for MFLO, 0 otherwise.
- MULTU result: {HI, LO} = 2*DATA_W-bit unsigned product.
- DIVU result: LO = quotient, HI = remainder.
- Divide by zero: same DATA_W latency, no exception. Result is LO = all ones, HI = dividend.
- md_req when busy_o is low is accepted even in the cycle done_o is high. Back-to-back operations have no bubble beyond the stall.
- Reset: state IDLE, counter 0, HI = LO = 0, busy_o = done_o = 0. Reset mid-operation aborts it with no HI/LO write.
- Reset dominates a simultaneous issue_i.

Decomposition:
- Shared package holds:
  - ALUOp encodings and funct encodings (ADD, SUB, AND, OR, NOR, SLT, MULTU, DIVU, MFHI, MFLO).
  - ALU control codes (0000/0001/0010/0110/0111/1100/1111).
  - State enum.
- One natural sub-module, md_iter_core: iterative multiplier/divider datapath with start/op/done.
- alu_ctrl_md contains the decode, stall logic and HI/LO.

Test Plan:
- Decode sweep: every ALUOp × listed funct -> ALUCtrl_o per table. ALUOp 010 with funct 011000 -> 1111, no busy.
- MULTU rs=0x0000FFFF, rt=0x0000FFFF -> busy 32 cycles, done pulse, HI=0x00000000, LO=0xFFFE0001. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678 after 32 cycles.
- MFLO issued 5 cycles after MULTU accept -> stall_o=1 until busy_o falls, then mf_valid_o=1 with the new LO. ADD issued while busy -> stall_o=0, ALUCtrl_o=0010.
- Back-to-back: DIVU held under stall behind MULTU -> accepted the cycle busy_o drops, second result correct.
- rst_i at cycle 10 of DIVU -> busy_o=0 next cycle, HI=LO=0, no done_o pulse.
